// File: rtl/vga_text_line_renderer.sv
// 640x480@60 VGA timing generator that draws NUM_CHARS scaled 8x16 ASCII glyphs in one row.
// Character codes are shadowed once per frame; syncs, active and pixel leave one aligned pipeline.
module vga_text_line_renderer #(
  parameter int CLK_DIV   = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int NUM_CHARS = 3,
  parameter int SCALE_X   = 25,
  parameter int SCALE_Y   = 10,
  parameter int ORIGIN_X  = 20,
  parameter int ORIGIN_Y  = 160
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_CHARS-1:0] char_codes,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   pixel_on,
  output logic                   video_active,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
  localparam int XSW = (SCALE_X   > 1) ? $clog2(SCALE_X)   : 1;
  localparam int YSW = (SCALE_Y   > 1) ? $clog2(SCALE_Y)   : 1;
  localparam int SW  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_LO    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_LO    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] RX_LO    = HW'(ORIGIN_X);
  localparam logic [HW-1:0] RX_HI    = HW'(ORIGIN_X + 8 * SCALE_X * NUM_CHARS);
  localparam logic [VW-1:0] RY_LO    = VW'(ORIGIN_Y);
  localparam logic [VW-1:0] RY_HI    = VW'(ORIGIN_Y + 16 * SCALE_Y);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Glyph rows are stored as 8 rows and doubled vertically to form the 16-row cell.
  function automatic logic [7:0] glyph_row(input logic [7:0] code, input logic [2:0] r);
    logic [7:0]  c;
    logic [63:0] g;
    c = (code >= 8'h61 && code <= 8'h7A) ? code - 8'h20 : code;
    case (c)
      8'h41: g = 64'h183C66667E666600;  8'h42: g = 64'h7C66667C66667C00;
      8'h43: g = 64'h3C66606060663C00;  8'h44: g = 64'h786C6666666C7800;
      8'h45: g = 64'h7E60607C60607E00;  8'h46: g = 64'h7E60607C60606000;
      8'h47: g = 64'h3C66606E66663C00;  8'h48: g = 64'h6666667E66666600;
      8'h49: g = 64'h3C18181818183C00;  8'h4A: g = 64'h1E0C0C0C0C6C3800;
      8'h4B: g = 64'h666C7870786C6600;  8'h4C: g = 64'h6060606060607E00;
      8'h4D: g = 64'h63777F6B63636300;  8'h4E: g = 64'h66767E7E6E666600;
      8'h4F: g = 64'h3C66666666663C00;  8'h50: g = 64'h7C66667C60606000;
      8'h51: g = 64'h3C666666663C0E00;  8'h52: g = 64'h7C66667C786C6600;
      8'h53: g = 64'h3C66603C06663C00;  8'h54: g = 64'h7E18181818181800;
      8'h55: g = 64'h6666666666663C00;  8'h56: g = 64'h66666666663C1800;
      8'h57: g = 64'h6363636B7F776300;  8'h58: g = 64'h66663C183C666600;
      8'h59: g = 64'h6666663C18181800;  8'h5A: g = 64'h7E060C1830607E00;
      8'h30: g = 64'h3C666E7666663C00;  8'h31: g = 64'h1838181818187E00;
      8'h32: g = 64'h3C66060C30607E00;  8'h33: g = 64'h3C66061C06663C00;
      8'h34: g = 64'h060E1E667F060600;  8'h35: g = 64'h7E607C0606663C00;
      8'h36: g = 64'h3C66607C66663C00;  8'h37: g = 64'h7E660C1818181800;
      8'h38: g = 64'h3C66663C66663C00;  8'h39: g = 64'h3C66663E06663C00;
      8'h20: g = 64'h0;
      default: g = 64'h0;
    endcase
    return g[{~r, 3'b000} +: 8];
  endfunction

  logic [DW-1:0]  div_q;
  logic           tick;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [XSW-1:0] xs_q, xs_d;
  logic [2:0]     col_q, col_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [YSW-1:0] ys_q, ys_d;
  logic [3:0]     row_q, row_d;
  logic           line_end;
  logic [7:0]     shadow_q [NUM_CHARS];

  logic           s1_hs_q, s1_vs_q, s1_act_q, s1_reg_q, s1_first_q;
  logic [SW-1:0]  s1_slot_q;
  logic [2:0]     s1_row_q, s1_col_q;
  logic           h_sync_q, v_sync_q, active_q, pixel_q, frame_start_q;
  logic [7:0]     glyph_bits;
  logic           pixel_d;

  assign tick     = (div_q == DIV_LAST);
  assign line_end = (hcnt_q == H_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    xs_d   = xs_q;
    col_d  = col_q;
    slot_d = slot_q;
    ys_d   = ys_q;
    row_d  = row_q;
    if (tick) begin
      if (line_end) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
      // Horizontal glyph sub-counters restart where the text region begins on every line.
      if (hcnt_d == RX_LO) begin
        xs_d   = '0;
        col_d  = '0;
        slot_d = '0;
      end else if (xs_q == XSW'(SCALE_X - 1)) begin
        xs_d = '0;
        if (col_q == 3'd7) begin
          col_d  = '0;
          slot_d = (slot_q == SW'(NUM_CHARS - 1)) ? '0 : slot_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        xs_d = xs_q + 1'b1;
      end
      if (line_end) begin
        if (vcnt_d == RY_LO) begin
          ys_d  = '0;
          row_d = '0;
        end else if (ys_q == YSW'(SCALE_Y - 1)) begin
          ys_d  = '0;
          row_d = row_q + 1'b1;
        end else begin
          ys_d = ys_q + 1'b1;
        end
      end
    end
  end

  assign glyph_bits = glyph_row(shadow_q[s1_slot_q], s1_row_q);
  assign pixel_d    = s1_act_q & s1_reg_q & glyph_bits[~s1_col_q];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      xs_q   <= '0;
      col_q  <= '0;
      slot_q <= '0;
      ys_q   <= '0;
      row_q  <= '0;
    end else begin
      div_q  <= tick ? '0 : div_q + 1'b1;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      xs_q   <= xs_d;
      col_q  <= col_d;
      slot_q <= slot_d;
      ys_q   <= ys_d;
      row_q  <= row_d;
    end
  end

  // NOTE: the shadow array is reset on purpose: the first frame after reset must render spaces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) shadow_q[i] <= 8'h20;
    end else if (tick && hcnt_q == '0 && vcnt_q == V_ACT) begin
      for (int i = 0; i < NUM_CHARS; i++) shadow_q[i] <= char_codes[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      s1_act_q      <= 1'b0;
      s1_reg_q      <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_slot_q     <= '0;
      s1_row_q      <= '0;
      s1_col_q      <= '0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      active_q      <= 1'b0;
      pixel_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick & s1_first_q;
      if (tick) begin
        s1_hs_q    <= !(hcnt_q >= HS_LO && hcnt_q < HS_HI);
        s1_vs_q    <= !(vcnt_q >= VS_LO && vcnt_q < VS_HI);
        s1_act_q   <= (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        s1_reg_q   <= (hcnt_q >= RX_LO) && (hcnt_q < RX_HI) &&
                      (vcnt_q >= RY_LO) && (vcnt_q < RY_HI);
        s1_first_q <= (hcnt_q == '0) && (vcnt_q == '0);
        s1_slot_q  <= slot_q;
        s1_row_q   <= row_q[3:1];
        s1_col_q   <= col_q;
        h_sync_q   <= s1_hs_q;
        v_sync_q   <= s1_vs_q;
        active_q   <= s1_act_q;
        pixel_q    <= pixel_d;
      end
    end
  end

  assign h_sync       = h_sync_q;
  assign v_sync       = v_sync_q;
  assign video_active = active_q;
  assign pixel_on     = pixel_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_text_line_renderer.sv
// Randomized bench for vga_text_line_renderer on a shrunken raster, compared every clock
// against a position-based reference model (x/y arithmetic, font lookup, per-frame code capture).
module tb_vga_text_line_renderer;

  localparam int CLK_DIV = 2;
  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VS = 2, VBP = 3;
  localparam int NC = 3, SX = 2, SY = 2, OX = 6, OY = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int FRAME_CLK = FRAME * CLK_DIV;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*NC-1:0] char_codes = '0;
  logic            h_sync, v_sync, pixel_on, video_active, frame_start;

  int vectors = 0;
  int miscompares = 0;

  vga_text_line_renderer #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .NUM_CHARS(NC), .SCALE_X(SX), .SCALE_Y(SY), .ORIGIN_X(OX), .ORIGIN_Y(OY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .char_codes(char_codes),
    .h_sync(h_sync), .v_sync(v_sync), .pixel_on(pixel_on),
    .video_active(video_active), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  // Reference 8x8 font, bit 7 leftmost; each row covers two of the 16 glyph lines.
  function automatic logic [63:0] font(input logic [7:0] code);
    logic [7:0] c;
    c = (code >= "a" && code <= "z") ? code - 8'd32 : code;
    case (c)
      "A": return 64'h183C66667E666600;  "B": return 64'h7C66667C66667C00;
      "C": return 64'h3C66606060663C00;  "D": return 64'h786C6666666C7800;
      "E": return 64'h7E60607C60607E00;  "F": return 64'h7E60607C60606000;
      "G": return 64'h3C66606E66663C00;  "H": return 64'h6666667E66666600;
      "I": return 64'h3C18181818183C00;  "J": return 64'h1E0C0C0C0C6C3800;
      "K": return 64'h666C7870786C6600;  "L": return 64'h6060606060607E00;
      "M": return 64'h63777F6B63636300;  "N": return 64'h66767E7E6E666600;
      "O": return 64'h3C66666666663C00;  "P": return 64'h7C66667C60606000;
      "Q": return 64'h3C666666663C0E00;  "R": return 64'h7C66667C786C6600;
      "S": return 64'h3C66603C06663C00;  "T": return 64'h7E18181818181800;
      "U": return 64'h6666666666663C00;  "V": return 64'h66666666663C1800;
      "W": return 64'h6363636B7F776300;  "X": return 64'h66663C183C666600;
      "Y": return 64'h6666663C18181800;  "Z": return 64'h7E060C1830607E00;
      "0": return 64'h3C666E7666663C00;  "1": return 64'h1838181818187E00;
      "2": return 64'h3C66060C30607E00;  "3": return 64'h3C66061C06663C00;
      "4": return 64'h060E1E667F060600;  "5": return 64'h7E607C0606663C00;
      "6": return 64'h3C66607C66663C00;  "7": return 64'h7E660C1818181800;
      "8": return 64'h3C66663C66663C00;  "9": return 64'h3C66663E06663C00;
      default: return 64'h0;
    endcase
  endfunction

  // Expected outputs for raster position q (linear pixel index since the frame origin).
  task automatic expect_at(input int q, input logic [8*NC-1:0] codes,
                           output logic hs, output logic vs, output logic act, output logic pix);
    int x, y, slot, col, row;
    logic [63:0] g;
    logic [7:0]  line_bits;
    x   = q % HT;
    y   = (q / HT) % VT;
    hs  = !(x >= HA + HFP && x < HA + HFP + HS);
    vs  = !(y >= VA + VFP && y < VA + VFP + VS);
    act = (x < HA) && (y < VA);
    pix = 1'b0;
    if (act && x >= OX && x < OX + 8*SX*NC && y >= OY && y < OY + 16*SY) begin
      slot      = (x - OX) / (8*SX);
      col       = ((x - OX) / SX) % 8;
      row       = (y - OY) / SY;
      g         = font(codes[8*slot +: 8]);
      line_bits = g[8*(7 - row/2) +: 8];
      pix       = line_bits[7 - col];
    end
  endtask

  int          n = 0;
  int          last_fs = -1;
  logic [8*NC-1:0] shadow_m = {NC{8'h20}};
  logic        e_hs = 1'b1, e_vs = 1'b1, e_act = 1'b0, e_pix = 1'b0, e_fs = 1'b0;

  // Model: pixel ticks every CLK_DIV clocks; outputs after tick k show raster position k-2.
  initial begin
    int k;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; last_fs = -1; shadow_m = {NC{8'h20}};
        e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_pix = 1'b0; e_fs = 1'b0;
      end else begin
        n++;
        e_fs = 1'b0;
        if (n % CLK_DIV == 0) begin
          k = n / CLK_DIV;
          if (k >= 2) begin
            expect_at(k - 2, shadow_m, e_hs, e_vs, e_act, e_pix);
            e_fs = ((k - 2) % FRAME == 0);
          end
          if ((k - 1) % FRAME == VA * HT) shadow_m = char_codes;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("h_sync", h_sync, e_hs);
      check("v_sync", v_sync, e_vs);
      check("video_active", video_active, e_act);
      check("pixel_on", pixel_on, e_pix);
      check("frame_start", frame_start, e_fs);
      if (frame_start === 1'b1 && rst_n) begin
        if (last_fs >= 0) check("frame_period_clk", n - last_fs, FRAME_CLK);
        last_fs = n;
      end
    end
  end

  function automatic logic [8*NC-1:0] rand_codes();
    logic [8*NC-1:0] r;
    for (int i = 0; i < NC; i++) begin
      case ($urandom_range(0, 5))
        0: r[8*i +: 8] = 8'(8'h41 + $urandom_range(0, 25));
        1: r[8*i +: 8] = 8'(8'h61 + $urandom_range(0, 25));
        2: r[8*i +: 8] = 8'(8'h30 + $urandom_range(0, 9));
        3: r[8*i +: 8] = 8'h20;
        4: r[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h00;
        default: r[8*i +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    char_codes = {"I", "Q", "A"};
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    // Frame 0 renders spaces; mid-way through frame 1 (showing IQA) the codes change.
    repeat (FRAME_CLK + FRAME_CLK / 2) @(negedge clk);
    char_codes = {"Z", "9", "B"};
    repeat (FRAME_CLK) @(negedge clk);
    char_codes = {8'h00, "q", 8'h7F};
    repeat (FRAME_CLK) @(negedge clk);
    char_codes = {"0", "Q", "q"};
    repeat (FRAME_CLK) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      char_codes = rand_codes();
      repeat ($urandom_range(800, 2400)) @(negedge clk);
    end
    // Asynchronous reset between clock edges must clear the outputs at once.
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_h_sync", h_sync, 1);
    check("async_rst_v_sync", v_sync, 1);
    check("async_rst_pixel_on", pixel_on, 0);
    check("async_rst_video_active", video_active, 0);
    check("async_rst_frame_start", frame_start, 0);
    repeat (3) @(negedge clk);
    char_codes = rand_codes();
    rst_n = 1'b1;
    repeat (FRAME_CLK + FRAME_CLK / 3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
